// File: rtl/sram_bridge.sv
// Responder on the CPU memory port: runs timed single-word cycles on an asynchronous SRAM and holds mwait high while one is in progress.
// Optional one-entry read cache with write-through: define BRIDGE_RDCACHE_EN.
module sram_bridge #(
    parameter int          RD_WAIT  = 2,
    parameter int          WR_WAIT  = 2,
    parameter logic [8:0]  RAM_PAGE = 9'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  addr,
    input  logic [15:0] d,
    output logic [15:0] q,
    input  logic        rd,
    input  logic        wr,
    output logic        mwait,
    output logic [18:0] rama,
    inout  wire  [15:0] ramd,
    output logic        ramcs,
    output logic        ramoe,
    output logic        ramwe
);

    localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    typedef enum logic [2:0] {IDLE, RSTRB, WSETUP, WSTRB, WHOLD, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [18:0]   rama_q, rama_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   q_q, q_d;
    logic          hit;

`ifdef BRIDGE_RDCACHE_EN
    logic [9:0] tag_q, tag_d;
    logic       tvld_q, tvld_d;

    assign hit = rd && !wr && tvld_q && (tag_q == addr);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rama_q  <= '0;
            wdata_q <= '0;
            q_q     <= '0;
`ifdef BRIDGE_RDCACHE_EN
            tag_q   <= '0;
            tvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rama_q  <= rama_d;
            wdata_q <= wdata_d;
            q_q     <= q_d;
`ifdef BRIDGE_RDCACHE_EN
            tag_q   <= tag_d;
            tvld_q  <= tvld_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rama_d  = rama_q;
        wdata_d = wdata_q;
        q_d     = q_q;
`ifdef BRIDGE_RDCACHE_EN
        tag_d   = tag_q;
        tvld_d  = tvld_q;
`endif
        case (state_q)
            IDLE: begin
                // A write wins over a simultaneous read; a cache hit never leaves IDLE.
                if (wr) begin
                    rama_d  = {RAM_PAGE, addr};
                    wdata_d = d;
                    state_d = WSETUP;
                end else if (rd && !hit) begin
                    rama_d  = {RAM_PAGE, addr};
                    cnt_d   = CW'(RD_WAIT - 1);
                    state_d = RSTRB;
                end
            end
            RSTRB: begin
                if (cnt_q == '0) begin
                    q_d     = ramd;
                    state_d = DONE;
`ifdef BRIDGE_RDCACHE_EN
                    tag_d   = rama_q[9:0];
                    tvld_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WSETUP: begin
                cnt_d   = CW'(WR_WAIT - 1);
                state_d = WSTRB;
            end
            WSTRB: begin
                if (cnt_q == '0) state_d = WHOLD;
                else             cnt_d   = cnt_q - CW'(1);
            end
            WHOLD: begin
                state_d = DONE;
`ifdef BRIDGE_RDCACHE_EN
                if (tvld_q && (tag_q == rama_q[9:0])) q_d = wdata_q;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset releases them at once.
    assign ramcs = !((state_q == RSTRB) || (state_q == WSETUP) ||
                     (state_q == WSTRB) || (state_q == WHOLD));
    assign ramoe = (state_q != RSTRB);
    assign ramwe = (state_q != WSTRB);
    assign ramd  = ((state_q == WSETUP) || (state_q == WSTRB) || (state_q == WHOLD))
                   ? wdata_q : 16'hzzzz;

    assign mwait = !reset && (((state_q != IDLE) && (state_q != DONE)) ||
                              ((state_q == IDLE) && (rd || wr) && !hit));
    assign rama  = rama_q;
    assign q     = q_q;

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Memory-side responder for the mini-EDSAC CPU memory port. It accepts single-word read and write requests on the CPU's 10-bit address / 16-bit data interface and stretches them with `mwait` while it runs timed cycles on an external asynchronous SRAM. It sits between the CPU and the board SRAM pins (19-bit address, 16-bit bidirectional data, active-low CS/OE/WE) and runs on the divided core clock.

## Interface

Parameters:
- `RD_WAIT`, default 2: clock cycles `ramoe` is held low before `ramd` is sampled (≥1).
- `WR_WAIT`, default 2: clock cycles `ramwe` is held low (≥1).
- `RAM_PAGE`, default 9'h000: upper SRAM address bits [18:10].

Ports:
- `clock`  in  1: core clock. One clock domain; all logic on the rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `addr`  in  10: word address; must be stable while `rd`/`wr` is high.
- `d`  in  16: write data; must be stable while `wr` is high.
- `q`  out  16: read data, registered.
- `rd`  in  1: read request.
- `wr`  in  1: write request.
- `mwait`  out  1: access in progress; the requester holds its request while this is high.
- `rama`  out  19: SRAM address, registered, equal to {`RAM_PAGE`, `addr`}.
- `ramd`  inout  16: SRAM data. Driven only in write states, high-Z otherwise.
- `ramcs`  out  1: SRAM chip select, active-low.
- `ramoe`  out  1: SRAM output enable, active-low.
- `ramwe`  out  1: SRAM write enable, active-low.

## Operation

- States:
  - IDLE
  - RSTRB: CS and OE low.
  - WSETUP: CS low, `ramd` driven, WE high.
  - WSTRB: WE low.
  - WHOLD: WE high, `ramd` still driven, CS low.
  - DONE
- `mwait` is combinational: it is high when state ∉ {IDLE, DONE}, or when state = IDLE and (`rd`|`wr`) and the access is not a cache hit. `mwait` is forced 0 while `reset` is high.
- IDLE behaviour:
  - On a clock edge with `wr` high, latch `rama` and the write data, then go to WSETUP.
  - Otherwise, on a clock edge with `rd` high, latch `rama`, then go to RSTRB.
  - `wr` has priority if both are high; `rd` is ignored in that case.
- Read path:
  - RSTRB lasts `RD_WAIT` cycles, counted with a down-counter.
  - On the last RSTRB edge, `q` <= `ramd`, then go to DONE.
- Write path:
  - WSETUP lasts 1 cycle.
  - WSTRB lasts `WR_WAIT` cycles.
  - WHOLD lasts 1 cycle, then go to DONE.
- DONE lasts 1 cycle:
  - `mwait` = 0, all SRAM strobes high, `q` valid after a read.
  - The next state is always IDLE.
  - A request still asserted in the following IDLE cycle is treated as a new access (back-to-back accesses are legal).
- `q` holds its value until the next read completes (see Configuration for the cache exception).
- Reset, including mid-access:
  - State → IDLE immediately.
  - `ramcs`/`ramoe`/`ramwe` = 1, `ramd` = Z.
  - `q` = 0, `rama` = 0, `mwait` = 0, counter = 0.
  - A write interrupted by reset leaves SRAM contents undefined at that address.

## Timing

- Read: `mwait` is high for `RD_WAIT`+1 cycles, counted from the first cycle `rd` is seen in IDLE. `q` is valid in the DONE cycle. Default: 3 cycles.
- Write: `mwait` is high for `WR_WAIT`+3 cycles. Default: 5 cycles.
- `rama` is stable from the cycle after the request through DONE.
- `ramd` is driven for the whole of WSETUP, WSTRB and WHOLD, which gives one cycle of address/data setup and hold around the WE pulse.
- OE and WE are never low in the same cycle. `ramd` is never driven while OE is low.

## Configuration

- `BRIDGE_RDCACHE_EN` defined: one-entry read cache.
  - It holds a tag (`addr`) plus a valid bit. `q` is the cache data register.
  - A completed read loads the tag, sets valid and loads `q`.
  - A read in IDLE whose `addr` equals a valid tag is a hit: `mwait` stays 0, no SRAM cycle runs, `q` is already correct, and the state stays IDLE.
  - A write to the tagged address also updates `q` at DONE (write-through). Writes to other addresses leave the cache unchanged.
  - Reset clears the valid bit.
- `BRIDGE_RDCACHE_EN` undefined: every read performs an SRAM cycle. No tag logic is present.

## Test plan

- Reset, then hold `reset` high for 3 cycles → `ramcs`=`ramoe`=`ramwe`=1, `ramd`=Z, `q`=0, `mwait`=0.
- `wr`=1, `addr`=10'h155, `d`=16'hBEEF, default parameters → `mwait` high for 5 cycles; `rama`=19'h00155; `ramwe` low for exactly 2 cycles with `ramd`=16'hBEEF from WSETUP through WHOLD.
- SRAM model returns 16'hBEEF at 19'h00155; then `rd`=1, `addr`=10'h155 → `mwait` high for 3 cycles; `q`=16'hBEEF in the DONE cycle.
- `rd` and `wr` both high, `addr`=10'h001, `d`=16'h1234 → write cycle only; `ramoe` never low.
- Reset asserted in the second WSTRB cycle → in that same cycle `ramwe`=1 and `ramd`=Z; the next request is serviced normally.
- With `BRIDGE_RDCACHE_EN`: read 10'h020 twice back-to-back → the first read shows `mwait` high for 3 cycles, the second shows `mwait`=0 with no OE pulse. Write 16'h0042 to 10'h020 → `q`=16'h0042.
